// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined radix-4 Booth multiplier: op encoding,
// latency constants, Booth digit type and tree-sizing helpers.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    localparam int unsigned LAT_BASE    = 3;
    localparam int unsigned LAT_OUT_REG = 4;

    // One recoded multiplier digit in {-2,-1,0,+1,+2}
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_dig_t;

    // Operands are extended by two bits so the top digit absorbs sign/zero handling
    function automatic int unsigned pp_count(input int unsigned xlen);
        return xlen / 2 + 1;
    endfunction

    // Vector count after lvl layers of 3:2 compression (each full triple becomes two)
    function automatic int unsigned csa_level_cnt(input int unsigned n, input int unsigned lvl);
        int unsigned cnt;
        cnt = n;
        for (int unsigned i = 0; i < lvl; i++) begin
            cnt = cnt - cnt / 3;
        end
        return cnt;
    endfunction

    function automatic int unsigned csa_levels(input int unsigned n);
        int unsigned cnt;
        int unsigned lvl;
        cnt = n;
        lvl = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (cnt > 2) begin
                cnt = cnt - cnt / 3;
                lvl = lvl + 1;
            end
        end
        return lvl;
    endfunction

    // Triplet {b[2i+1], b[2i], b[2i-1]} -> digit; 111 and 000 both give zero without neg
    function automatic booth_dig_t booth_enc(input logic [2:0] t);
        booth_dig_t d;
        d.one = t[1] ^ t[0];
        d.two = (t[2] & ~t[1] & ~t[0]) | (~t[2] & t[1] & t[0]);
        d.neg = t[2] & ~(t[1] & t[0]);
        return d;
    endfunction

endpackage

// File: rtl/mul_pipe_booth_csa_tree.sv
// Purely combinational 3:2 carry-save reduction of N W-bit vectors to sum + carry.
module csa_tree
    import mul_pkg::*;
#(
    parameter int unsigned N = 3,
    parameter int unsigned W = 8
) (
    input  logic [N*W-1:0] vecs_i,
    output logic [W-1:0]   sum_o,
    output logic [W-1:0]   carry_o
);

    localparam int unsigned LEVELS = csa_levels(N);

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned NCUR = csa_level_cnt(N, l);
        logic [W-1:0] v [NCUR];

        if (l == 0) begin : g_in
            for (genvar i = 0; i < NCUR; i++) begin : g_v
                assign v[i] = vecs_i[i*W +: W];
            end
        end else begin : g_csa
            localparam int unsigned NPREV = csa_level_cnt(N, l - 1);
            localparam int unsigned NGRP  = NPREV / 3;

            // Full triples compress; carry is shifted up one bit and truncated to W
            for (genvar g = 0; g < NGRP; g++) begin : g_grp
                logic [W-1:0] x, y, z;
                assign x = g_lvl[l-1].v[3*g];
                assign y = g_lvl[l-1].v[3*g+1];
                assign z = g_lvl[l-1].v[3*g+2];
                assign v[2*g]   = x ^ y ^ z;
                assign v[2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
            end

            for (genvar r = 0; r < NPREV - 3 * NGRP; r++) begin : g_pass
                assign v[2*NGRP+r] = g_lvl[l-1].v[3*NGRP+r];
            end
        end
    end

    assign sum_o   = g_lvl[LEVELS].v[0];
    assign carry_o = g_lvl[LEVELS].v[1];

endmodule

// File: rtl/mul_pipe_booth.sv
// 3-stage radix-4 Booth multiplier (encode / CSA tree / final add) with a global stall.
// Define MUL_PIPE_OUT_REG_EN to add a fourth registered output stage.
module mul_pipe_booth
    import mul_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned PW   = 2 * XLEN;
    localparam int unsigned EW   = XLEN + 2;
    localparam int unsigned NPP  = pp_count(XLEN);
    localparam int unsigned NVEC = NPP + 1;

    logic stall;
    logic accept;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // S1: operand extension and Booth recoding of the multiplier
    mul_op_e            op_in;
    logic               a_sgn;
    logic               b_sgn;
    logic [EW-1:0]      s1_a_d;
    logic [EW:0]        b_pad;
    booth_dig_t [NPP-1:0] s1_dig_d;

    assign op_in = mul_op_e'(in_op);

    always_comb begin
        a_sgn  = (op_in == OP_MULH) || (op_in == OP_MULHSU);
        b_sgn  = (op_in == OP_MULH);
        s1_a_d = {{2{a_sgn & in_a[XLEN-1]}}, in_a};
        b_pad  = {{2{b_sgn & in_b[XLEN-1]}}, in_b, 1'b0};
        for (int i = 0; i < NPP; i++) begin
            s1_dig_d[i] = booth_enc(b_pad[2*i +: 3]);
        end
    end

    logic                 s1_valid_q, s2_valid_q, s3_valid_q;
    logic                 s1_valid_d, s2_valid_d, s3_valid_d;
    mul_op_e              s1_op_q, s2_op_q;
    logic [TAG_W-1:0]     s1_tag_q, s2_tag_q;
    logic [EW-1:0]        s1_a_q;
    booth_dig_t [NPP-1:0] s1_dig_q;

    // S2: partial products (inverted rows plus a +1 correction row) into the tree
    logic [PW-1:0]      a_sx;
    logic [PW-1:0]      mag;
    logic [PW-1:0]      pp;
    logic [PW-1:0]      corr;
    logic [NVEC*PW-1:0] vecs;

    always_comb begin
        a_sx = {{(PW-EW){s1_a_q[EW-1]}}, s1_a_q};
        mag  = '0;
        pp   = '0;
        corr = '0;
        vecs = '0;
        for (int i = 0; i < NPP; i++) begin
            mag = s1_dig_q[i].one ? a_sx : (s1_dig_q[i].two ? (a_sx << 1) : '0);
            pp  = s1_dig_q[i].neg ? ~mag : mag;
            vecs[i*PW +: PW] = pp << (2 * i);
            corr[2*i]        = s1_dig_q[i].neg;
        end
        vecs[NPP*PW +: PW] = corr;
    end

    logic [PW-1:0] s2_sum_d, s2_carry_d;
    logic [PW-1:0] s2_sum_q, s2_carry_q;

    csa_tree #(
        .N (NVEC),
        .W (PW)
    ) u_csa_tree (
        .vecs_i  (vecs),
        .sum_o   (s2_sum_d),
        .carry_o (s2_carry_d)
    );

    // S3: carry-propagate add and half select
    logic [PW-1:0]    full_prod;
    logic [XLEN-1:0]  s3_res_d;
    logic [XLEN-1:0]  s3_res_q;
    logic [TAG_W-1:0] s3_tag_q;

    always_comb begin
        full_prod = s2_sum_q + s2_carry_q;
        s3_res_d  = (s2_op_q == OP_MUL) ? full_prod[XLEN-1:0] : full_prod[PW-1:XLEN];
    end

`ifdef MUL_PIPE_OUT_REG_EN
    logic             s4_valid_q, s4_valid_d;
    logic [XLEN-1:0]  s4_res_q;
    logic [TAG_W-1:0] s4_tag_q;
`endif

    // Flush wins over everything; otherwise the whole pipe moves only when not stalled
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s3_valid_d = s3_valid_q;
`ifdef MUL_PIPE_OUT_REG_EN
        s4_valid_d = s4_valid_q;
`endif
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s3_valid_d = 1'b0;
`ifdef MUL_PIPE_OUT_REG_EN
            s4_valid_d = 1'b0;
`endif
        end else if (!stall) begin
            s1_valid_d = accept;
            s2_valid_d = s1_valid_q;
            s3_valid_d = s2_valid_q;
`ifdef MUL_PIPE_OUT_REG_EN
            s4_valid_d = s3_valid_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_res_q   <= '0;
            s3_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            if (!stall) begin
                s3_res_q <= s3_res_d;
                s3_tag_q <= s2_tag_q;
            end
        end
    end

    // Datapath payload needs no reset; valid bits qualify it
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_op_q    <= op_in;
            s1_tag_q   <= in_tag;
            s1_a_q     <= s1_a_d;
            s1_dig_q   <= s1_dig_d;
            s2_op_q    <= s1_op_q;
            s2_tag_q   <= s1_tag_q;
            s2_sum_q   <= s2_sum_d;
            s2_carry_q <= s2_carry_d;
        end
    end

`ifdef MUL_PIPE_OUT_REG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s4_valid_q <= 1'b0;
            s4_res_q   <= '0;
            s4_tag_q   <= '0;
        end else begin
            s4_valid_q <= s4_valid_d;
            if (!stall) begin
                s4_res_q <= s3_res_q;
                s4_tag_q <= s3_tag_q;
            end
        end
    end

    assign out_valid  = s4_valid_q;
    assign out_result = s4_res_q;
    assign out_tag    = s4_tag_q;
`else
    assign out_valid  = s3_valid_q;
    assign out_result = s3_res_q;
    assign out_tag    = s3_tag_q;
`endif

endmodule

// File: tb/tb_mul_pipe_booth.sv
// Self-checking bench for mul_pipe_booth: directed corner cases plus random ops
// against a plain-arithmetic product model and an in-order expectation queue.
module tb_mul_pipe_booth;
    import mul_pkg::*;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned TAG_W = 5;
`ifdef MUL_PIPE_OUT_REG_EN
    localparam int LAT = LAT_OUT_REG;
`else
    localparam int LAT = LAT_BASE;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    logic ready_mode;
    logic ready_val;
    logic rnd_ready;

    assign out_ready = ready_mode ? rnd_ready : ready_val;

    mul_pipe_booth #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        int               cyc;
        bit               lat;
    } exp_t;

    exp_t            q[$];
    int              checks;
    int              failures;
    int              cyc;
    logic [XLEN-1:0] cur_exp;
    bit              cur_lat;

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Exact product of the operands interpreted per op, reduced mod 2^128
    function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [127:0] ax, bx, p;
        ax = (op == OP_MULH || op == OP_MULHSU) ? {{64{a[63]}}, a} : {64'b0, a};
        bx = (op == OP_MULH) ? {{64{b[63]}}, b} : {64'b0, b};
        p  = ax * bx;
        return (op == OP_MUL) ? p[63:0] : p[127:64];
    endfunction

    function automatic logic [XLEN-1:0] pick();
        logic [XLEN-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'h0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            4:       v = 64'h1;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    always @(posedge clk) cyc++;

    initial rnd_ready = 1'b1;
    always @(posedge clk) begin
        #1 rnd_ready = ($urandom_range(0, 9) < 8);
    end

    // Output monitor and expectation scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            check_eq("in_ready", 128'(in_ready), 128'(!(out_valid && !out_ready)));
            if (q.size() == 0) begin
                check_eq("idle_valid", 128'(out_valid), 128'(0));
            end else if (out_valid) begin
                check_eq("result", 128'(out_result), 128'(q[0].res));
                check_eq("tag", 128'(out_tag), 128'(q[0].tag));
                if (out_ready) begin
                    if (q[0].lat) check_eq("latency", 128'(cyc - q[0].cyc), 128'(LAT));
                    void'(q.pop_front());
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back('{cur_exp, in_tag, cyc, cur_lat});
        end
    end

    task automatic send(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp, input bit lat,
                        input bit fl);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        cur_exp  = exp;
        cur_lat  = lat;
        flush    = fl;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
        if (!acc) check_eq("send_timeout", 128'(acc), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain_empty", 128'(q.size()), 128'(0));
    endtask

    initial begin
        logic [XLEN-1:0]  ra, rb;
        logic [1:0]       rop;
        logic [TAG_W-1:0] rtag;
        bit               rfl;

        checks     = 0;
        failures   = 0;
        cyc        = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_op      = 2'b00;
        in_a       = '0;
        in_b       = '0;
        in_tag     = '0;
        flush      = 1'b0;
        ready_mode = 1'b0;
        ready_val  = 1'b1;
        cur_exp    = '0;
        cur_lat    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_in_ready", 128'(in_ready), 128'(1));
        check_eq("rst_out_result", 128'(out_result), 128'(0));
        check_eq("rst_out_tag", 128'(out_tag), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(OP_MUL, 64'd3, 64'd5, 5'd7, 64'd15, 1'b1, 1'b0);
        drain();

        send(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
        send(OP_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'h0, 1'b1, 1'b0);
        send(OP_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd10,
             64'h4000_0000_0000_0000, 1'b1, 1'b0);
        send(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        send(OP_MULHSU, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 64'd1, 1'b1, 1'b0);
        drain();

        // Back-to-back ops against a consumer that holds off, then releases
        ready_val = 1'b0;
        fork
            begin
                for (int t = 1; t <= 4; t++) begin
                    ra  = pick();
                    rb  = pick();
                    rop = 2'($urandom_range(0, 3));
                    send(rop, ra, rb, 5'(t), ref_mul(rop, ra, rb), 1'b0, 1'b0);
                end
            end
            begin
                repeat (LAT + 5) @(posedge clk);
                #1;
                ready_val = 1'b1;
            end
        join
        drain();

        // Flush kills two in-flight ops; a later op sees normal latency
        send(OP_MUL, 64'd11, 64'd13, 5'd14, 64'd143, 1'b0, 1'b0);
        send(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 5'd15, 64'hF, 1'b0, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        send(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 5'd21, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0);
        drain();

        // Reset with three ops in flight and the oldest already presented
        send(OP_MUL, 64'd2, 64'd3, 5'd1, 64'd6, 1'b0, 1'b0);
        send(OP_MUL, 64'd4, 64'd5, 5'd2, 64'd20, 1'b0, 1'b0);
        send(OP_MUL, 64'd6, 64'd7, 5'd3, 64'd42, 1'b0, 1'b0);
        repeat (LAT - 3) begin
            @(posedge clk);
            #1;
        end
        check_eq("pre_rst_out_valid", 128'(out_valid), 128'(1));
        rst = 1'b1;
        #1;
        check_eq("rst_mid_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_mid_in_ready", 128'(in_ready), 128'(1));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(OP_MULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        drain();

        // Random traffic with random back-pressure, gaps and rare flushes
        ready_mode = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            rop  = 2'($urandom_range(0, 3));
            ra   = pick();
            rb   = pick();
            rtag = 5'($urandom());
            rfl  = ($urandom_range(0, 199) == 0);
            send(rop, ra, rb, rtag, ref_mul(rop, ra, rb), 1'b0, rfl);
        end
        ready_mode = 1'b0;
        ready_val  = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_pipe_booth.md
MUL_PIPE_BOOTH -- requirements
Module: mul_pipe_booth

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand width; even value, 8 or more.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried with each operation.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation offered.
REQ-006 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-007 SHALL have port in_op  input  2  00 MUL (low XLEN), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
REQ-008 SHALL have ports in_a, in_b  input  XLEN  multiplicand, multiplier.
REQ-009 SHALL have port in_tag  input  TAG_W  sideband, returned unchanged with the result.
REQ-010 SHALL have port flush  input  1  kills every in-flight operation.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-013 SHALL have ports out_result  output  XLEN  and out_tag  output  TAG_W.

Function
REQ-014 SHALL form XLEN/2+1 radix-4 Booth partial products from in_a and in_b, each sign/zero-extended per in_op to (XLEN+2) bits of operand, product width 2*XLEN.
REQ-015 SHALL reduce all partial products to one sum and one carry vector with 3:2 carry-save layers, carry shifted left one bit per layer, truncated to 2*XLEN.
REQ-016 SHALL be a 3-stage pipeline: S1 Booth encode, S2 compression tree, S3 final carry-propagate add plus high/low select; each stage holds a valid bit, op, and tag.
REQ-017 SHALL produce out_result exactly 3 cycles after acceptance when out_ready stays high (4 with REQ-027 macro).
REQ-018 SHALL compute the result modulo 2^(2*XLEN) equal to mathematically exact product for all operand values, including most-negative signed values.
REQ-019 SHALL stall all stages together when out_valid && !out_ready; in_ready = !(out_valid && !out_ready); stalled stages hold contents unchanged.
REQ-020 SHALL accept one operation per cycle when not stalled; no bubbles inserted by the block.
REQ-021 SHALL deliver results in acceptance order; no operation lost or duplicated.
REQ-022 SHALL on flush clear all stage valid bits on the next edge; an operation offered in the same cycle as flush is dropped; in_ready ignores flush.
REQ-023 SHALL hold out_result and out_tag stable while out_valid && !out_ready.

Reset
REQ-024 SHALL on rst clear all stage valid bits immediately (asynchronous): out_valid 0, in_ready 1.
REQ-025 SHALL reset out_result and out_tag to 0; datapath registers other than valid bits need not reset.
REQ-026 SHALL, on rst asserted mid-operation, discard all in-flight operations; first result after release belongs to first operation accepted after release.

Configuration
REQ-027 SHALL support macro MUL_PIPE_OUT_REG_EN: defined adds a registered output stage S4 (latency 4, same stall/flush rules); undefined, outputs driven from S3 (latency 3).

Structure
REQ-028 SHALL place the in_op encoding enum, latency constants, and partial-product count function in shared package mul_pkg.
REQ-029 SHALL implement the reduction tree as sub-module csa_tree, parametrised by input vector count and width, purely combinational, instantiated once in S2.

Verification
REQ-030 SHALL cover: MUL a=3, b=5, tag=7 -> out_result=15, out_tag=7, out_valid 3 cycles after accept.
REQ-031 SHALL cover: MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; MULH a=b=-1 -> 0; MULH a=b=0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000.
REQ-032 SHALL cover: MULHSU a=-1, b=2 -> 0xFFFF_FFFF_FFFF_FFFF; MULHSU a=2, b=0xFFFF_FFFF_FFFF_FFFF -> 1.
REQ-033 SHALL cover: 4 back-to-back ops tags 1..4, out_ready low 5 cycles -> in_ready low while stalled, results emerge tags 1,2,3,4 in order, none lost.
REQ-034 SHALL cover: 2 ops accepted, flush on next cycle -> out_valid never asserts for them; op accepted after flush returns after nominal latency.
REQ-035 SHALL cover: rst pulsed mid-way through 3 in-flight ops -> out_valid falls same cycle, in_ready 1, no stale result after release; 10k random ops vs. reference model match for every in_op.
